// File: rtl/led_pkg.sv
// Shared definitions for the LED fade sequencer: mode codes, FSM states and default widths.
package led_pkg;

    localparam int unsigned LEVEL_W_DEF = 4;
    localparam int unsigned DIV_W_DEF   = 16;
    localparam int unsigned HOLD_W_DEF  = 4;
    localparam int unsigned MODE_W      = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_UP      = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_DOWN    = 3'd3,
        ST_HOLD_LO = 3'd4
    } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..div and fires tick_c on the wrap cycle (period div+1).
module led_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick_c
);

    logic [DIV_W-1:0] cnt;

    assign tick_c = (cnt == div);

    always_ff @(posedge clk) begin
        if (reset || clear || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/led_fade_sequencer.sv
// Sequences a PWM intensity level through off / steady / blink / breathe patterns,
// advancing only on prescaler ticks; config is latched when a start is accepted.
module led_fade_sequencer
    import led_pkg::*;
#(
    parameter int unsigned LEVEL_W = LEVEL_W_DEF,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned HOLD_W  = HOLD_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [MODE_W-1:0]  mode,
    input  logic [LEVEL_W-1:0] max_level,
    input  logic [DIV_W-1:0]   step_div,
    input  logic [HOLD_W-1:0]  hold_steps,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               cycle_done
);

    state_e             state;
    mode_e              mode_q;
    logic [LEVEL_W-1:0] max_q;
    logic [DIV_W-1:0]   div_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic               stopping;

    logic start_ok_c;
    logic tick_c;
    logic hold_done_c;

    // Stop wins over a simultaneous start; start is only honoured from IDLE.
    assign start_ok_c  = (state == ST_IDLE) && start && !stop;
    assign hold_done_c = (hold_cnt == hold_q);

    led_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_ok_c),
        .div    (div_q),
        .tick_c (tick_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_OFF;
            max_q  <= '0;
            div_q  <= '0;
            hold_q <= '0;
        end else if (start_ok_c) begin
            mode_q <= mode_e'(mode);
            max_q  <= max_level;
            div_q  <= step_div;
            hold_q <= hold_steps;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            level      <= '0;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
            hold_cnt   <= '0;
            stopping   <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start_ok_c) begin
                    hold_cnt <= '0;
                    stopping <= 1'b0;
                    case (mode_e'(mode))
                        MODE_STEADY, MODE_BLINK: begin
                            state <= ST_HOLD_HI;
                            busy  <= 1'b1;
                            level <= max_level;
                        end
                        MODE_BREATHE: begin
                            state <= (max_level == '0) ? ST_HOLD_HI : ST_UP;
                            busy  <= 1'b1;
                            level <= '0;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end else if (stop && !stopping) begin
                // A lit breathe ramps down gracefully; everything else drops out at once.
                hold_cnt <= '0;
                if (mode_q == MODE_BREATHE && level != '0) begin
                    stopping <= 1'b1;
                    state    <= ST_DOWN;
                end else begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    level <= '0;
                end
            end else if (tick_c) begin
                case (state)
                    ST_UP: begin
                        if (level != max_q) begin
                            level <= LEVEL_W'(level + 1'b1);
                        end
                        if (LEVEL_W'(level + 1'b1) == max_q) begin
                            state <= ST_HOLD_HI;
                        end
                    end
                    ST_HOLD_HI: begin
                        if (mode_q != MODE_STEADY) begin
                            if (hold_done_c) begin
                                hold_cnt <= '0;
                                if (mode_q == MODE_BREATHE && level != '0) begin
                                    state <= ST_DOWN;
                                end else begin
                                    state <= ST_HOLD_LO;
                                    level <= '0;
                                end
                            end else begin
                                hold_cnt <= HOLD_W'(hold_cnt + 1'b1);
                            end
                        end
                    end
                    ST_DOWN: begin
                        if (level != '0) begin
                            level <= LEVEL_W'(level - 1'b1);
                        end
                        if (level == LEVEL_W'(1)) begin
                            if (stopping) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                stopping <= 1'b0;
                            end else begin
                                state <= ST_HOLD_LO;
                            end
                        end
                    end
                    ST_HOLD_LO: begin
                        if (hold_done_c) begin
                            hold_cnt   <= '0;
                            cycle_done <= 1'b1;
                            if (mode_q == MODE_BLINK || max_q == '0) begin
                                state <= ST_HOLD_HI;
                                level <= max_q;
                            end else begin
                                state <= ST_UP;
                            end
                        end else begin
                            hold_cnt <= HOLD_W'(hold_cnt + 1'b1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        level <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Bench for led_fade_sequencer: directed scenarios plus random traffic against a
// closed-form model that derives level from the tick count within the pattern period.
module tb_led_fade_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [3:0]  max_level;
    logic [15:0] step_div;
    logic [3:0]  hold_steps;
    logic [3:0]  level;
    logic        busy;
    logic        cycle_done;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_busy, m_stopping, m_cd;
    int m_level, m_mode, m_max, m_div, m_hold, m_c;

    int lv [0:40];
    int cdv[0:40];

    led_fade_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .max_level  (max_level),
        .step_div   (step_div),
        .hold_steps (hold_steps),
        .level      (level),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    function automatic int period();
        int h = m_hold + 1;
        if (m_mode == 2) return 2 * h;
        return 2 * m_max + 2 * h;
    endfunction

    // Level after k ticks since start, from the shape of one pattern period.
    function automatic int ref_level(int k);
        int h = m_hold + 1;
        int kk;
        case (m_mode)
            1: return m_max;
            2: return ((k % period()) < h) ? m_max : 0;
            3: begin
                kk = k % period();
                if (kk <= m_max) return kk;
                if (kk <= m_max + h) return m_max;
                if (kk <= 2 * m_max + h) return 2 * m_max + h - kk;
                return 0;
            end
            default: return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit tick;
        int k;
        m_cd = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_level = 0; m_stopping = 1'b0;
        end else if (!m_busy) begin
            if (start && !stop && mode != 2'd0) begin
                m_mode = int'(mode); m_max = int'(max_level);
                m_div = int'(step_div); m_hold = int'(hold_steps);
                m_c = 0; m_busy = 1'b1; m_stopping = 1'b0;
                m_level = ref_level(0);
            end
        end else begin
            m_c++;
            tick = ((m_c % (m_div + 1)) == 0);
            if (stop && !m_stopping) begin
                if (m_mode == 3 && m_level > 0) m_stopping = 1'b1;
                else begin m_busy = 1'b0; m_level = 0; end
            end else if (m_stopping) begin
                if (tick) begin
                    m_level--;
                    if (m_level == 0) begin m_busy = 1'b0; m_stopping = 1'b0; end
                end
            end else if (tick) begin
                k = m_c / (m_div + 1);
                m_level = ref_level(k);
                m_cd = (m_mode != 1) && ((k % period()) == 0);
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("level", 32'(level), 32'(m_level));
        check("busy", 32'(busy), 32'(m_busy));
        check("cycle_done", 32'(cycle_done), 32'(m_cd));
    endtask

    task automatic cfg(input int md, input int mx, input int dv, input int hd);
        mode = 2'(md); max_level = 4'(mx); step_div = 16'(dv); hold_steps = 4'(hd);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        cfg(0, 0, 0, 0);
        m_busy = 1'b0; m_stopping = 1'b0; m_cd = 1'b0;
        m_level = 0; m_mode = 0; m_max = 0; m_div = 0; m_hold = 0; m_c = 0;
        step(); step();
        reset = 1'b0;
        check("reset_level", 32'(level), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // BREATHE trace: div=2, max=3, hold=1
        cfg(3, 3, 2, 1);
        pulse_start();
        for (int i = 1; i <= 40; i++) begin
            step();
            lv[i] = int'(level); cdv[i] = int'(cycle_done);
        end
        check("br_lv2", 32'(lv[2]), 32'd0);
        check("br_lv3", 32'(lv[3]), 32'd1);
        check("br_lv6", 32'(lv[6]), 32'd2);
        check("br_lv9", 32'(lv[9]), 32'd3);
        check("br_lv15", 32'(lv[15]), 32'd3);
        check("br_lv17", 32'(lv[17]), 32'd3);
        check("br_lv18", 32'(lv[18]), 32'd2);
        check("br_lv21", 32'(lv[21]), 32'd1);
        check("br_lv24", 32'(lv[24]), 32'd0);
        check("br_cd29", 32'(cdv[29]), 32'd0);
        check("br_cd30", 32'(cdv[30]), 32'd1);
        check("br_cd31", 32'(cdv[31]), 32'd0);
        check("br_lv33", 32'(lv[33]), 32'd1);
        do_reset();

        // Reset mid-BREATHE at level 2, then a fresh start
        cfg(3, 5, 0, 0);
        pulse_start();
        step(); step();
        check("mid_lv2", 32'(level), 32'd2);
        do_reset();
        check("rst_mid_level", 32'(level), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_cd", 32'(cycle_done), 32'd0);
        pulse_start();
        for (int i = 0; i < 14; i++) step();
        do_reset();

        // BLINK at full rate, then stop
        cfg(2, 15, 0, 0);
        pulse_start();
        check("blink_first", 32'(level), 32'd15);
        for (int i = 0; i < 8; i++) step();
        pulse_stop();
        check("blink_stop_level", 32'(level), 32'd0);
        check("blink_stop_busy", 32'(busy), 32'd0);

        // BREATHE stop at level 3 during UP
        cfg(3, 10, 1, 2);
        pulse_start();
        for (int i = 0; i < 6; i++) step();
        check("up_lv3", 32'(level), 32'd3);
        pulse_stop();
        for (int i = 0; i < 5; i++) step();
        check("ramp_end_level", 32'(level), 32'd0);
        check("ramp_end_busy", 32'(busy), 32'd0);

        // Start and stop together from IDLE
        cfg(1, 7, 0, 0);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);

        // STEADY, then start while busy with different config
        pulse_start();
        for (int i = 0; i < 4; i++) step();
        cfg(2, 3, 0, 0);
        pulse_start();
        check("restart_ignored", 32'(level), 32'd7);
        for (int i = 0; i < 4; i++) step();
        pulse_stop();

        // OFF start
        cfg(0, 9, 0, 0);
        pulse_start();
        check("off_busy", 32'(busy), 32'd0);

        // BREATHE with max=0
        cfg(3, 0, 0, 1);
        pulse_start();
        for (int i = 0; i < 12; i++) step();
        pulse_stop();
        do_reset();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 499) == 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 29) == 0);
            cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            step();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
